gpio_uart_tx: RTL and testbench

- Downstream consumer of the memory controller's GPIO byte port.
- Each byte the CPU stores to the GPIO address arrives as gpio_data qualified by gpio_en. The block buffers it in a small FIFO and serialises it as 8N1 UART on a single tx pin, which streams processed image/pixel data off-chip to a host PC.
- Sits between the memory subsystem and the board's UART pin; it never stalls the CPU.

---
 rtl/gpio_uart_tx.sv | 190 +++++++++++++++++++
 tb/tb_gpio_uart_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_uart_tx.sv
// GPIO byte port to UART transmitter: a small FIFO feeding an 8N1 serialiser.
// Define GPIO_UART_PARITY_EN to insert an even-parity bit (8E1 framing).
module gpio_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gpio_data,
  input  logic       gpio_en,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          w_full, w_push, w_pop, w_drop;

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;
  logic          r_busy, r_full, r_ovf;
  logic          w_baud_tc;
`ifdef GPIO_UART_PARITY_EN
  logic          r_par, w_par_nxt;
`endif

  // A pop while full frees the slot the simultaneous push needs.
  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
  assign w_push = gpio_en && (!w_full || w_pop);
  assign w_drop = gpio_en && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= gpio_data;
  end

  assign w_baud_tc = (r_baud == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
`ifdef GPIO_UART_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_shift_nxt = r_mem[r_rptr];
`ifdef GPIO_UART_PARITY_EN
          w_par_nxt   = ^r_mem[r_rptr];
`endif
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_tc) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_tc) begin
          w_baud_nxt  = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_bit == 3'd7) begin
`ifdef GPIO_UART_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
`ifdef GPIO_UART_PARITY_EN
      S_PARITY: begin
        if (w_baud_tc) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_STOP;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_tc) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: begin
        w_baud_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // tx is registered from the next state so the pin never glitches on decode.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef GPIO_UART_PARITY_EN
      S_PARITY: w_tx_nxt = w_par_nxt;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef GPIO_UART_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_drop) r_ovf  <= 1'b1;
      r_count <= w_count_nxt;
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
      r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
`ifdef GPIO_UART_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  assign tx        = r_tx;
  assign busy      = r_busy;
  assign fifo_full = r_full;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Scoreboard bench for gpio_uart_tx: a line decoder pops expected bytes per frame.
// Honours GPIO_UART_PARITY_EN to expect 8E1 framing.
module tb_gpio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef GPIO_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] gpio_data = 8'h00;
  logic       gpio_en = 1'b0;
  logic       tx, busy, fifo_full, overflow;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         push_cyc = 0;
  logic       mon_en = 1'b0;
  logic       mon_busy = 1'b0;
  logic [7:0] exp_q[$];
  int         starts_q[$];

  gpio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .gpio_data (gpio_data),
    .gpio_en   (gpio_en),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Line decoder: detects the start bit and samples each bit at its midpoint.
  initial begin
    logic [7:0] rx;
    logic [7:0] e;
    logic       par;
    rx  = '0;
    par = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && rst && tx === 1'b0) begin
        mon_busy = 1'b1;
        starts_q.push_back(cyc);
        repeat (CPB / 2) @(negedge clk);
        chk("start_bit", tx, 0);
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge clk);
          rx[b] = tx;
        end
`ifdef GPIO_UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        par = tx;
`endif
        repeat (CPB) @(negedge clk);
        chk("stop_bit", tx, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", {24'h0, rx}, 32'h1FF);
        end else begin
          e = exp_q.pop_front();
          chk("rx_byte", rx, e);
`ifdef GPIO_UART_PARITY_EN
          chk("parity_bit", par, ^e);
`endif
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic push_byte(input logic [7:0] d);
    @(negedge clk);
    gpio_en   = 1'b1;
    gpio_data = d;
    push_cyc  = cyc;
    @(negedge clk);
    gpio_en   = 1'b0;
    gpio_data = 8'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (n >= budget), 0);
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    while (starts_q.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("start_timeout", (n >= budget), 0);
  endtask

  initial begin
    int n;
    int s;
    int bad;

    // Reset held: strobes must be ignored.
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gpio_en   = ~gpio_en;
      gpio_data = 8'($urandom);
    end
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", overflow, 0);
    gpio_en = 1'b0;
    rst     = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_tx", tx, 1);
    chk("post_rst_busy", busy, 0);

    // Single byte: start latency, bit pattern, busy duration.
    mon_en = 1'b1;
    starts_q.delete();
    exp_q.push_back(8'hA5);
    push_byte(8'hA5);
    wait_start(20);
    s = (starts_q.size() > 0) ? starts_q[0] : 0;
    chk("start_latency", s - push_cyc, 2);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("busy_fall", cyc - s, FRAME_CLKS);
    wait_idle(200);

    // Burst of 6 into a 4-deep FIFO: 0x06 is dropped.
    starts_q.delete();
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    @(negedge clk);
    gpio_en   = 1'b1;
    gpio_data = 8'h01;
    push_cyc  = cyc;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("burst_full%0d", i), fifo_full, (i >= 4));
      chk($sformatf("burst_ovf%0d", i), overflow, (i >= 5));
      if (i < 5) gpio_data = 8'(i + 2);
      else gpio_en = 1'b0;
    end
    wait_idle(2000);
    chk("burst_nframes", starts_q.size(), 5);
    for (int i = 1; i < starts_q.size(); i++)
      chk($sformatf("burst_gap%0d", i), starts_q[i] - starts_q[i-1], FRAME_CLKS + 1);
    chk("ovf_sticky", overflow, 1);
    chk("burst_full_end", fifo_full, 0);

    // Back-to-back frames with one idle-high clock between them.
    starts_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    @(negedge clk);
    gpio_en   = 1'b1;
    gpio_data = 8'h00;
    @(negedge clk);
    gpio_data = 8'hFF;
    @(negedge clk);
    gpio_en   = 1'b0;
    wait_idle(500);
    chk("b2b_nframes", starts_q.size(), 2);
    if (starts_q.size() == 2) chk("b2b_gap", starts_q[1] - starts_q[0], FRAME_CLKS + 1);

`ifdef GPIO_UART_PARITY_EN
    exp_q.push_back(8'h07);
    push_byte(8'h07);
    wait_idle(500);
    exp_q.push_back(8'h03);
    push_byte(8'h03);
    wait_idle(500);
`endif

    // Reset in the middle of data bit 3 of 0x55.
    mon_en = 1'b0;
    push_byte(8'h55);
    while (cyc < push_cyc + 2 + 3 * CPB + CPB + 1) @(negedge clk);
    chk("b3_line_low", tx, 0);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_full", fifo_full, 0);
    chk("mid_rst_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("no_residual", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
